// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronises raw IRQ lines, latches rising edges as pending requests,
// and issues a one-cycle break for the highest eligible source. A nesting stack records
// the sources being serviced, and each eret pops one level off that stack.
module irq_arbiter #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_NEST    = 4
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic [N_SRC-1:0] in_IRQ,
  input  logic             in_IE,
  input  logic [N_SRC-1:0] in_INM,
  input  logic             in_eret,
  input  logic             in_HOLD,
  output logic             out_BK,
  output logic             out_NIE,
  output logic [1:0]       out_code,
  output logic [N_SRC-1:0] out_PEND,
  output logic [2:0]       out_DEPTH
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BREAK   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] MAX_D = 3'(MAX_NEST);

  // Synchroniser chain and edge-history flops.
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];
  logic [N_SRC-1:0] hist_q, hist_d;
  logic [N_SRC-1:0] rise;

  // Arbitration state.
  state_t           state_q, state_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [1:0]       stack_q [MAX_NEST];
  logic [1:0]       stack_d [MAX_NEST];
  logic [2:0]       depth_q, depth_d;
  logic [1:0]       code_q, code_d;
  logic             bk_q, bk_d;
  logic             nie_q, nie_d;

  // Top-of-stack and eligibility.
  logic             top_vld;
  logic [1:0]       top_idx;
  logic [N_SRC-1:0] elig;
  logic             any_elig;
  logic [1:0]       pick;

  // Shift raw lines through the synchroniser; history holds the previous synchronised value.
  always_comb begin
    sync_d[0] = in_IRQ;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    hist_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Register the synchroniser chain and edge history.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      hist_q <= hist_d;
    end
  end

  // Find the current top of stack and the highest eligible pending source above it.
  always_comb begin
    top_vld  = (depth_q != 3'd0);
    top_idx  = 2'd0;
    for (int j = 0; j < MAX_NEST; j++) begin
      if (int'(depth_q) == j + 1) begin
        top_idx = stack_q[j];
      end
    end
    elig     = '0;
    any_elig = 1'b0;
    pick     = 2'd0;
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = pend_q[i] & ~in_INM[i] & (~top_vld | (i > int'(top_idx)));
      if (elig[i]) begin
        any_elig = 1'b1;
        pick     = 2'(i);
      end
    end
  end

  // Next-state logic: break issue, push on leaving BREAK, pop on eret, edge capture.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    stack_d = stack_q;
    depth_d = depth_q;
    code_d  = code_q;
    bk_d    = 1'b0;
    nie_d   = 1'b1;
    case (state_q)
      ST_IDLE, ST_SERVICE: begin
        if (in_eret) begin
          // eret takes precedence; a request is reconsidered next cycle against the new top.
          if (state_q == ST_SERVICE) begin
            depth_d = depth_q - 3'd1;
            if (depth_q == 3'd1) begin
              state_d = ST_IDLE;
            end
          end
        end else if (in_IE && any_elig && !in_HOLD && (depth_q < MAX_D)) begin
          state_d = ST_BREAK;
          code_d  = pick;
          bk_d    = 1'b1;
          nie_d   = 1'b0;
        end
      end
      ST_BREAK: begin
        // The break has been accepted: retire the request and open a service level.
        for (int i = 0; i < N_SRC; i++) begin
          if (2'(i) == code_q) begin
            pend_d[i] = 1'b0;
          end
        end
        for (int j = 0; j < MAX_NEST; j++) begin
          if (int'(depth_q) == j) begin
            stack_d[j] = code_q;
          end
        end
        depth_d = depth_q + 3'd1;
        state_d = ST_SERVICE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A fresh edge in the same cycle as the clear keeps the request pending.
    pend_d = pend_d | rise;
  end

  // Register FSM state, stack and outputs.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      for (int j = 0; j < MAX_NEST; j++) begin
        stack_q[j] <= 2'd0;
      end
      depth_q <= 3'd0;
      code_q  <= 2'd0;
      bk_q    <= 1'b0;
      nie_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      for (int j = 0; j < MAX_NEST; j++) begin
        stack_q[j] <= stack_d[j];
      end
      depth_q <= depth_d;
      code_q  <= code_d;
      bk_q    <= bk_d;
      nie_q   <= nie_d;
    end
  end

  assign out_BK    = bk_q;
  assign out_NIE   = nie_q;
  assign out_code  = code_q;
  assign out_PEND  = pend_q;
  assign out_DEPTH = depth_q;

endmodule
